// File: rtl/ramdisk_pkg.sv
// Shared definitions for the multi-unit RAM disk: FSM state encoding,
// RK05 drive geometry and a constant clog2 used for derived widths.
package ramdisk_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_RD   = 4'd1,
    ST_WR   = 4'd2,
    ST_DONE = 4'd3,
    ST_ERR  = 4'd4
  } state_e;

  localparam int SURFACES         = 2;
  localparam int SECTORS          = 12;
  localparam int WORDS_PER_SECTOR = 256;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ramdisk_mem.sv
// Single-port synchronous RAM shared by all drives; one-cycle read latency,
// read data holds its value while no read is requested.
module ramdisk_mem
  import ramdisk_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int AW     = 15
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] ram [0:(2**AW)-1];

  // Write has priority; the controller never requests both in one cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      ram[addr] <= wdata;
    end else if (re) begin
      rdata <= ram[addr];
    end
  end

endmodule

// File: rtl/ramdisk_array.sv
// Multi-unit block RAM disk: command FSM, physical address generation and
// the flow-controlled handshakes towards the read and write FIFOs.
module ramdisk_array
  import ramdisk_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 256,
  parameter int BLOCKS      = 60,
  parameter int UNITS       = 2,
  parameter int UNIT_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  output logic              device_ready,
  input  logic              read_cmd,
  input  logic              write_cmd,
  input  logic [UNIT_W-1:0] unit,
  input  logic [31:0]       block_address,
  output logic              cmd_done,
  output logic              cmd_error,
  output logic              fifo_clk,
  input  logic [DATA_W-1:0] write_data,
  output logic              write_data_enable,
  input  logic              write_fifo_empty,
  output logic [DATA_W-1:0] read_data,
  output logic              read_data_enable,
  input  logic              read_fifo_full,
  output logic [15:0]       debug
);

  localparam int WORD_W = clog2(BLOCK_WORDS);
  localparam int MEM_AW = clog2(UNITS * BLOCKS * BLOCK_WORDS);
  localparam int CNT_W  = WORD_W + 1;

  localparam logic [CNT_W-1:0] BW_CNT   = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] BW_LAST  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [31:0]      UNITS_U  = 32'(UNITS);
  localparam logic [31:0]      BLOCKS_U = 32'(BLOCKS);
  localparam logic [31:0]      BW_U     = 32'(BLOCK_WORDS);

  state_e              state_q;
  logic [CNT_W-1:0]    wordCnt_q;
  logic [MEM_AW-1:0]   base_q;
  logic                ready_q;
  logic                done_q;
  logic                error_q;
  logic                push_q;
  logic                wrPend_q;

  logic [MEM_AW-1:0]   base_d;
  logic [MEM_AW-1:0]   memAddr;
  logic [CNT_W-1:0]    popsMade;
  logic                cmdValid;
  logic                rdIssue;
  logic                wrPop;
  logic                memWe;
  logic [DATA_W-1:0]   memRdata;

  // Strobes are gated by reset so a pending pop, push or RAM write is dropped
  // on the very edge that aborts the transfer.
  always_comb begin
    popsMade = wordCnt_q + CNT_W'(wrPend_q);
    rdIssue  = reset && (state_q == ST_RD) && !read_fifo_full && (wordCnt_q < BW_CNT);
    wrPop    = reset && (state_q == ST_WR) && !write_fifo_empty && (popsMade < BW_CNT);
    memWe    = reset && wrPend_q;
    memAddr  = base_q + MEM_AW'(wordCnt_q);
    cmdValid = (32'(unit) < UNITS_U) && (block_address < BLOCKS_U);
    base_d   = MEM_AW'((32'(unit) * BLOCKS_U + block_address) * BW_U);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wordCnt_q <= '0;
      base_q    <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      push_q    <= 1'b0;
      wrPend_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      push_q   <= rdIssue;
      wrPend_q <= wrPop;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && (read_cmd || write_cmd)) begin
            ready_q   <= 1'b0;
            wordCnt_q <= '0;
            base_q    <= base_d;
            if (!cmdValid) begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end else if (read_cmd) begin
              state_q <= ST_RD;
            end else begin
              state_q <= ST_WR;
            end
          end
        end
        ST_RD: begin
          // The last push is in flight while the counter sits at BW_CNT.
          if (rdIssue) begin
            wordCnt_q <= wordCnt_q + 1'b1;
          end
          if (wordCnt_q == BW_CNT) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_WR: begin
          if (memWe) begin
            wordCnt_q <= wordCnt_q + 1'b1;
            if (wordCnt_q == BW_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  ramdisk_mem #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .addr  (memAddr),
    .we    (memWe),
    .re    (rdIssue),
    .wdata (write_data),
    .rdata (memRdata)
  );

  assign device_ready      = ready_q;
  assign cmd_done          = done_q;
  assign cmd_error         = error_q;
  assign fifo_clk          = clk;
  assign read_data_enable  = push_q;
  assign read_data         = push_q ? memRdata : '0;
  assign write_data_enable = wrPop;
  assign debug             = {state_q, 2'b00, 10'(wordCnt_q)};

endmodule

// File: doc/ramdisk_array.md
# ramdisk_array

Parametrised multi-unit RAM disk built on FPGA Block RAM, the successor to the single-unit RK05-geometry RAM disk. It serves whole-block read and write commands from a disk controller for up to UNITS independent drives sharing one RAM. Both FIFO directions carry flow control: an empty write FIFO stalls writes and a full read FIFO stalls reads. Out-of-range unit or block addresses are rejected with an error pulse.

## Interface
- DATA_W, 16: word width.
- BLOCK_WORDS, 256: words per block; power of two, 2..1024.
- BLOCKS, 60: blocks per unit.
- UNITS, 2: number of drives, 1..8.
- UNIT_W, 3: width of the `unit` port.
- Derived: WORD_W = clog2(BLOCK_WORDS); MEM_AW = clog2(UNITS*BLOCKS*BLOCK_WORDS).

Ports:
- clk  in  1  single clock, 20MHz; all logic on the rising edge.
- reset  in  1  synchronous, active-low.
- device_ready  out  1  idle and able to accept a command.
- read_cmd  in  1  read request; sampled only while device_ready=1.
- write_cmd  in  1  write request; sampled only while device_ready=1.
- unit  in  UNIT_W  drive select; sampled at accept.
- block_address  in  32  block within the unit; sampled at accept.
- cmd_done  out  1  one-cycle pulse when a block transfer completes.
- cmd_error  out  1  one-cycle pulse when a command is rejected.
- fifo_clk  out  1  equals clk.
- write_data  in  DATA_W  write-FIFO head; valid the cycle after a pop.
- write_data_enable  out  1  write-FIFO pop strobe.
- write_fifo_empty  in  1  write FIFO has no data.
- read_data  out  DATA_W  word to the read FIFO.
- read_data_enable  out  1  read-FIFO push strobe; read_data valid in the same cycle.
- read_fifo_full  in  1  read FIFO has at most one free entry.
- debug  out  16  {state[3:0], 2'b0, word_counter[9:0]}.

## Operation
- States: IDLE, RD, WR, DONE, ERR.
- IDLE: device_ready=1.
  - read_cmd → RD; write_cmd → WR; read_cmd wins if both are high.
  - On accept: latch unit and block_address, clear word_counter.
  - unit ≥ UNITS or block_address ≥ BLOCKS → ERR instead; no RAM access occurs.
- Physical address = (unit*BLOCKS + block)*BLOCK_WORDS + word_counter, truncated to MEM_AW bits. The base is computed once at accept and registered.
- RD: each cycle with read_fifo_full=0, issue a RAM read and increment word_counter.
  - The cycle after each issue: read_data_enable=1 with the word on read_data.
  - After issuing word BLOCK_WORDS-1 → DONE.
  - The in-flight word is always pushed, even if full rises meanwhile. The single-entry headroom in read_fifo_full is what covers it.
- WR: each cycle with write_fifo_empty=0 and fewer than BLOCK_WORDS pops made, assert write_data_enable.
  - The cycle after each pop: write write_data to RAM and increment word_counter.
  - After the write of word BLOCK_WORDS-1 → DONE.
  - Empty stalls pops only; a write already pending still completes.
- DONE: cmd_done=1 for one cycle → IDLE.
- ERR: cmd_error=1 for one cycle → IDLE.
- word_counter is WORD_W+1 bits wide, so block-complete is detected without wrap ambiguity.
- write_fifo_empty during a stall: no timeout, the block waits indefinitely.

## Timing
- Reset (reset=0 at an edge):
  - state=IDLE.
  - device_ready, cmd_done, cmd_error, read_data_enable and write_data_enable all 0.
  - read_data=0, word_counter=0.
  - device_ready rises on the first edge with reset=1.
- Read, no stalls, accept at edge T:
  - RAM reads issued at T+1..T+BW.
  - read_data_enable at T+2..T+BW+1.
  - cmd_done at T+BW+2.
  - device_ready at T+BW+3.
- Write, no stalls, accept at T:
  - Pops at T+1..T+BW.
  - RAM writes at T+2..T+BW+1.
  - cmd_done at T+BW+2.
  - device_ready at T+BW+3.
- Each stall cycle delays every later event by exactly one cycle.
- Error path: accept at T → cmd_error at T+1 → device_ready at T+2.
- device_ready is 0 in every non-IDLE state. Commands held high across completion are re-accepted when device_ready returns.
- Reset mid-transfer: abort immediately; no cmd_done; any pending pop or push is dropped. RAM words already written are kept; the rest of the block is unchanged.
- Simultaneous RAM read and write cannot occur: the RAM is single-port and the FSM is exclusive.

## Structure
- Shared package `ramdisk_pkg`:
  - state encoding.
  - RK05 geometry constants (SURFACES=2, SECTORS=12, WORDS_PER_SECTOR=256).
  - clog2 function.
- Sub-module `ramdisk_mem`: single-port synchronous RAM, DATA_W × 2^MEM_AW, inferred as Block RAM. Inputs addr, we, re, wdata; rdata registered with 1-cycle latency and held while re=0.
- `ramdisk_array` contains only the FSM, address generation and handshakes.

## Test plan
- Write unit 0 block 0 with 0o4000+i, then read it back → 256 pushes of 0o4000..0o4377 in order; cmd_done 258 cycles after accept.
- Write unit 1 block 0 with 0o10000+i, then read unit 0 block 0 → data unchanged (units isolated).
- Write with write_fifo_empty toggling 1 cycle on / 1 cycle off → exactly 256 pops, correct data, cmd_done after 256 extra cycles.
- Read with read_fifo_full high for 10 cycles mid-block → no push lost or duplicated; pushes never exceed one past full assertion.
- block_address=60 or unit=2 with defaults → cmd_error at T+1, no strobes, device_ready at T+2.
- reset=0 at word 100 of a write, then read the same block → words 0..98 new, remainder old; no cmd_done for the aborted write.
